// File: rtl/apb_pkg.sv
// apb_pkg: shared protocol state encoding and default geometry for the
// APB register-file slave and its testbench.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int DEF_ADDR_WIDTH  = 8;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_DEPTH       = 16;
    localparam int DEF_WAIT_CYCLES = 0;

endpackage

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: word storage with one synchronous write port, one
// combinational read port and an asynchronous active-low clear.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int IDX_W      = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [IDX_W-1:0]      i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem <= '{default: '0};
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB slave exposing DEPTH word registers with a fixed number
// of wait states and PSLVERR for out-of-range, unstable or malformed transfers.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic                  i_pclk,
    input  logic                  i_preset_n,
    input  logic                  i_psel,
    input  logic                  i_penable,
    input  logic                  i_pwrite,
    input  logic [ADDR_WIDTH-1:0] i_paddr,
    input  logic [DATA_WIDTH-1:0] i_pwdata,
    output logic [DATA_WIDTH-1:0] o_prdata,
    output logic                  o_pready,
    output logic                  o_pslverr
);

    localparam int                  IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [3:0]          WAIT_L  = 4'(WAIT_CYCLES);

    apb_state_e            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [3:0]            r_cnt;
    logic                  r_done;
    logic                  r_perr;
    logic                  r_wdataMismatch;

    logic                  w_setupCyc;
    logic                  w_accessCyc;
    logic                  w_pending;
    logic                  w_pready;
    logic                  w_err;
    logic                  w_wen;
    logic [DATA_WIDTH-1:0] w_rdata;

    // A transfer is outstanding right after its setup cycle, and in ACCESS
    // until PREADY has been given; a finished ACCESS behaves like IDLE.
    assign w_setupCyc  = i_psel & ~i_penable;
    assign w_accessCyc = i_psel & i_penable;
    assign w_pending   = (r_state == SETUP) | ((r_state == ACCESS) & ~r_done);
    assign w_pready    = w_pending & w_accessCyc & (r_cnt == 4'd0);

    // PWDATA stability is tracked through a register so no output depends
    // combinationally on PWDATA; the captured data is what gets written.
    assign w_err = ({1'b0, r_addr} >= DEPTH_L) | (i_paddr != r_addr)
                 | (i_pwrite != r_write) | r_wdataMismatch | r_perr;
    assign w_wen = w_pready & r_write & ~w_err;

    assign o_pready  = w_pready;
    assign o_pslverr = w_pready & w_err;
    assign o_prdata  = (w_pready & ~r_write & ~w_err) ? w_rdata : '0;

    always_ff @(posedge i_pclk or negedge i_preset_n) begin
        if (!i_preset_n) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            r_write         <= 1'b0;
            r_wdata         <= '0;
            r_cnt           <= 4'd0;
            r_done          <= 1'b0;
            r_perr          <= 1'b0;
            r_wdataMismatch <= 1'b0;
        end else if (!w_pending) begin
            if (w_setupCyc) begin
                r_state         <= SETUP;
                r_addr          <= i_paddr;
                r_write         <= i_pwrite;
                r_wdata         <= i_pwdata;
                r_cnt           <= WAIT_L;
                r_done          <= 1'b0;
                r_wdataMismatch <= 1'b0;
            end else begin
                r_state <= IDLE;
                if (i_penable) begin
                    r_perr <= 1'b1;
                end
            end
        end else if (w_accessCyc) begin
            r_state <= ACCESS;
            r_done  <= w_pready;
            if (r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (!w_pready && (i_pwdata != r_wdata)) begin
                r_wdataMismatch <= 1'b1;
            end
            if (w_pready) begin
                r_perr <= 1'b0;
            end
        end else begin
            // Deselecting during wait states is a clean abort; anything
            // else that breaks the setup/access sequence is flagged.
            r_state <= IDLE;
            if ((r_state == SETUP) || i_psel) begin
                r_perr <= 1'b1;
            end
        end
    end

    apb_slave_regfile #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .IDX_W     (IDX_W)
    ) u_regfile (
        .i_clk  (i_pclk),
        .i_rst_n(i_preset_n),
        .i_we   (w_wen),
        .i_waddr(r_addr[IDX_W-1:0]),
        .i_wdata(r_wdata),
        .i_raddr(r_addr[IDX_W-1:0]),
        .o_rdata(w_rdata)
    );

endmodule
